vreg_bridge: RTL and testbench

VREG_BRIDGE -- requirements
Module: vreg_bridge

---
 rtl/vreg_bridge.sv | 131 +++++++++++++
 tb/tb_vreg_bridge.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_bridge.sv
// CPU byte-wide shadow of 32 16-bit display registers; dirty entries are streamed to the
// display controller by a rotating scan, deferred ones only inside a vsync-triggered window.
module vreg_bridge #(
  parameter logic [31:0] DEFER_MASK = 32'h0000_FFFF
) (
  input  logic        reg_clk,
  input  logic        nreset,
  input  logic [5:0]  cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_dout,
  input  logic        vsync_in,
  output logic        reg_wr,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_data,
  output logic        busy,
  output logic        in_window
);

  localparam logic [5:0] WINDOW_LEN = 6'd32;

  logic [15:0] shadow_r [32];
  logic [31:0] dirty_r;
  logic [7:0]  latch_r;
  logic [4:0]  scan_r;
  logic [5:0]  win_cnt_r;
  logic        sync1_r;
  logic        sync2_r;
  logic        sync_prev_r;

  logic [4:0]  cpu_idx_s;
  logic        hi_wr_s;
  logic        lo_wr_s;
  logic        win_open_s;
  logic        eligible_s;
  logic        vsync_fall_s;
  logic [31:0] clr_mask_s;
  logic [31:0] set_mask_s;
  logic [31:0] dirty_next_s;
  logic [5:0]  win_cnt_next_s;

  assign cpu_idx_s    = cpu_addr[5:1];
  assign hi_wr_s      = cpu_wr & cpu_addr[0];
  assign lo_wr_s      = cpu_wr & ~cpu_addr[0];
  assign win_open_s   = (win_cnt_r != 6'd0);
  assign eligible_s   = dirty_r[scan_r] & (~DEFER_MASK[scan_r] | win_open_s);
  assign vsync_fall_s = sync_prev_r & ~sync2_r;
  assign clr_mask_s   = eligible_s ? (32'd1 << scan_r) : 32'd0;
  assign set_mask_s   = hi_wr_s ? (32'd1 << cpu_idx_s) : 32'd0;
  // Set wins over clear: a write racing its own emission is re-sent on the next pass.
  assign dirty_next_s = (dirty_r & ~clr_mask_s) | set_mask_s;

  always_comb begin
    if (vsync_fall_s) begin
      win_cnt_next_s = WINDOW_LEN;
    end else if (win_open_s) begin
      win_cnt_next_s = win_cnt_r - 6'd1;
    end else begin
      win_cnt_next_s = 6'd0;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      for (int i = 0; i < 32; i++) begin
        shadow_r[i] <= 16'h0000;
      end
      latch_r <= 8'h00;
    end else begin
      if (hi_wr_s) begin
        shadow_r[cpu_idx_s] <= {cpu_data, latch_r};
      end
      if (lo_wr_s) begin
        latch_r <= cpu_data;
      end
    end
  end

  // reg_data samples the shadow before this edge's CPU write lands.
  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      scan_r   <= 5'd0;
      dirty_r  <= 32'd0;
      reg_wr   <= 1'b0;
      reg_addr <= 5'd0;
      reg_data <= 16'h0000;
    end else begin
      scan_r  <= scan_r + 5'd1;
      dirty_r <= dirty_next_s;
      reg_wr  <= eligible_s;
      if (eligible_s) begin
        reg_addr <= scan_r;
        reg_data <= shadow_r[scan_r];
      end
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      cpu_dout <= 8'h00;
    end else if (cpu_rd) begin
      cpu_dout <= cpu_addr[0] ? shadow_r[cpu_idx_s][15:8] : shadow_r[cpu_idx_s][7:0];
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      sync1_r     <= 1'b1;
      sync2_r     <= 1'b1;
      sync_prev_r <= 1'b1;
      win_cnt_r   <= 6'd0;
      in_window   <= 1'b0;
    end else begin
      sync1_r     <= vsync_in;
      sync2_r     <= sync1_r;
      sync_prev_r <= sync2_r;
      win_cnt_r   <= win_cnt_next_s;
      in_window   <= (win_cnt_next_s != 6'd0);
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      busy <= 1'b0;
    end else begin
      busy <= |dirty_r;
    end
  end

endmodule

// File: tb/tb_vreg_bridge.sv
// Bench for vreg_bridge: two instances (no deferral / default deferral) run in lockstep
// against a per-cycle behavioural model, plus directed scenario checks.
module tb_vreg_bridge;

  localparam logic [31:0] MASK0 = 32'h0000_0000;
  localparam logic [31:0] MASK1 = 32'h0000_FFFF;

  logic        reg_clk = 1'b0;
  logic        nreset;
  logic [5:0]  cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wr, cpu_rd, vsync_in;
  logic [7:0]  dout0, dout1;
  logic        wr0, wr1, busy0, busy1, win0, win1;
  logic [4:0]  addr0, addr1;
  logic [15:0] data0, data1;

  vreg_bridge #(.DEFER_MASK(MASK0)) dut0 (
    .reg_clk(reg_clk), .nreset(nreset), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_dout(dout0), .vsync_in(vsync_in),
    .reg_wr(wr0), .reg_addr(addr0), .reg_data(data0), .busy(busy0), .in_window(win0));

  vreg_bridge #(.DEFER_MASK(MASK1)) dut1 (
    .reg_clk(reg_clk), .nreset(nreset), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_dout(dout1), .vsync_in(vsync_in),
    .reg_wr(wr1), .reg_addr(addr1), .reg_data(data1), .busy(busy1), .in_window(win1));

  always #5 reg_clk = ~reg_clk;

  int total = 0;
  int bad = 0;
  int lock_bad = 0;
  logic [63:0] lock_act, lock_exp;

  // Behavioural model state, one slot per instance.
  logic [15:0] m_shadow [2][32];
  logic [31:0] m_dirty [2];
  logic [7:0]  m_latch [2];
  int          m_scan [2];
  int          m_wcnt [2];
  logic        m_s1, m_s2, m_s3;
  logic        m_wr [2];
  logic [4:0]  m_addr [2];
  logic [15:0] m_data [2];
  logic [7:0]  m_dout [2];
  logic        m_busy [2];
  logic        m_win [2];

  task automatic model_step();
    logic fall;
    int idx;
    logic [31:0] mask;
    if (!nreset) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 32; i++) m_shadow[k][i] = 16'h0000;
        m_dirty[k] = 32'd0; m_latch[k] = 8'h00; m_scan[k] = 0; m_wcnt[k] = 0;
        m_wr[k] = 1'b0; m_addr[k] = 5'd0; m_data[k] = 16'h0000; m_dout[k] = 8'h00;
        m_busy[k] = 1'b0; m_win[k] = 1'b0;
      end
      m_s1 = 1'b1; m_s2 = 1'b1; m_s3 = 1'b1;
    end else begin
      fall = m_s3 & ~m_s2;
      idx = int'(cpu_addr[5:1]);
      for (int k = 0; k < 2; k++) begin
        mask = (k == 0) ? MASK0 : MASK1;
        m_busy[k] = (m_dirty[k] != 32'd0);
        if (cpu_rd) m_dout[k] = cpu_addr[0] ? m_shadow[k][idx][15:8] : m_shadow[k][idx][7:0];
        if (m_dirty[k][m_scan[k]] && (!mask[m_scan[k]] || m_wcnt[k] > 0)) begin
          m_wr[k] = 1'b1;
          m_addr[k] = 5'(m_scan[k]);
          m_data[k] = m_shadow[k][m_scan[k]];
          m_dirty[k][m_scan[k]] = 1'b0;
        end else begin
          m_wr[k] = 1'b0;
        end
        if (cpu_wr && cpu_addr[0]) begin
          m_shadow[k][idx] = {cpu_data, m_latch[k]};
          m_dirty[k][idx] = 1'b1;
        end else if (cpu_wr) begin
          m_latch[k] = cpu_data;
        end
        m_wcnt[k] = fall ? 32 : ((m_wcnt[k] > 0) ? m_wcnt[k] - 1 : 0);
        m_win[k] = (m_wcnt[k] != 0);
        m_scan[k] = (m_scan[k] + 1) % 32;
      end
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = vsync_in;
    end
  endtask

  task automatic tick();
    logic [63:0] a, e;
    model_step();
    @(posedge reg_clk);
    #1;
    a = {6'd0, wr0, addr0, data0, dout0, busy0, win0, wr1, addr1, data1, dout1, busy1, win1};
    e = {6'd0, m_wr[0], m_addr[0], m_data[0], m_dout[0], m_busy[0], m_win[0],
         m_wr[1], m_addr[1], m_data[1], m_dout[1], m_busy[1], m_win[1]};
    if (a !== e) begin
      if (lock_bad == 0) begin lock_act = a; lock_exp = e; end
      lock_bad++;
    end
  endtask

  task automatic wr_byte(input logic [5:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_data = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic test_reset();
    nreset = 1'b0; vsync_in = 1'b1;
    cpu_addr = 6'h05; cpu_data = 8'hAA; cpu_wr = 1'b1; cpu_rd = 1'b1;
    repeat (3) tick();
    nreset = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0;
    total++;
    if ({wr0, addr0, data0, dout0, busy0, win0} !== 32'd0) begin
      bad++; $display("FAIL reset_outs0 got=%h exp=0", {wr0, addr0, data0, dout0, busy0, win0});
    end
    total++;
    if ({wr1, addr1, data1, dout1, busy1, win1} !== 32'd0) begin
      bad++; $display("FAIL reset_outs1 got=%h exp=0", {wr1, addr1, data1, dout1, busy1, win1});
    end
    repeat (4) tick();
    total++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      bad++; $display("FAIL reset_busy got=%b%b exp=00", busy0, busy1);
    end
    total++;
    if (lock_bad != 0) begin
      bad++; $display("FAIL lockstep_reset n=%0d got=%h exp=%h", lock_bad, lock_act, lock_exp);
    end
    lock_bad = 0;
  endtask

  task automatic test_basic();
    int hits = 0, lat = -1, hits1 = 0;
    logic [15:0] got = 16'h0;
    logic [4:0] gaddr = 5'h0;
    logic busy_early = 1'b0;
    wr_byte(6'h04, 8'h34);
    wr_byte(6'h05, 8'h12);
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) busy_early = busy0;
      if (wr0) begin
        hits++; got = data0; gaddr = addr0;
        if (lat < 0) lat = n;
      end
      if (wr1 && addr1 == 5'd2) hits1++;
    end
    total++;
    if (hits != 1 || lat < 1 || lat > 33) begin
      bad++; $display("FAIL basic_count hits=%0d latency=%0d exp 1 within 33", hits, lat);
    end
    total++;
    if (gaddr !== 5'd2 || got !== 16'h1234) begin
      bad++; $display("FAIL basic_data got=%0d/%h exp=2/1234", gaddr, got);
    end
    total++;
    if (busy_early !== 1'b1 || busy0 !== 1'b0) begin
      bad++; $display("FAIL basic_busy got=%b->%b exp=1->0", busy_early, busy0);
    end
    total++;
    if (hits1 != 0) begin
      bad++; $display("FAIL basic_deferred got=%0d exp=0", hits1);
    end
    total++;
    if (lock_bad != 0) begin
      bad++; $display("FAIL lockstep_basic n=%0d got=%h exp=%h", lock_bad, lock_act, lock_exp);
    end
    lock_bad = 0;
  endtask

  task automatic test_readback();
    logic [7:0] hi, lo;
    cpu_rd = 1'b1; cpu_addr = 6'h05; tick(); hi = dout0;
    cpu_addr = 6'h04; tick(); lo = dout0;
    cpu_rd = 1'b0;
    total++;
    if (hi !== 8'h12 || lo !== 8'h34) begin
      bad++; $display("FAIL readback got=%h/%h exp=12/34", hi, lo);
    end
    cpu_addr = 6'h05;
    repeat (3) tick();
    total++;
    if (dout0 !== 8'h34 || dout1 !== 8'h34) begin
      bad++; $display("FAIL readback_hold got=%h/%h exp=34/34", dout0, dout1);
    end
    total++;
    if (lock_bad != 0) begin
      bad++; $display("FAIL lockstep_readback n=%0d got=%h exp=%h", lock_bad, lock_act, lock_exp);
    end
    lock_bad = 0;
  endtask

  task automatic test_defer();
    int h16 = 0, h1 = 0, first1 = -1, wcount = 0, rises = 0, open_at = -1;
    logic [15:0] d16 = 16'h0, d1 = 16'h0;
    logic prev;
    vsync_in = 1'b1;
    wr_byte(6'h02, 8'h00); wr_byte(6'h03, 8'h0F);
    wr_byte(6'h20, 8'hBC); wr_byte(6'h21, 8'h0A);
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (wr1 && addr1 == 5'd16) begin h16++; d16 = data1; end
      if (wr1 && addr1 == 5'd1) h1++;
    end
    total++;
    if (h16 != 1 || d16 !== 16'h0ABC || h1 != 0) begin
      bad++; $display("FAIL defer_hold got h16=%0d d=%h h1=%0d exp 1/0abc/0", h16, d16, h1);
    end
    vsync_in = 1'b0;
    prev = win1;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (wr1 && addr1 == 5'd1 && first1 < 0) begin first1 = n; d1 = data1; end
      if (win1) wcount++;
      if (win1 && !prev) begin rises++; if (open_at < 0) open_at = n; end
      prev = win1;
    end
    total++;
    if (first1 < 1 || first1 > 35 || d1 !== 16'h0F00) begin
      bad++; $display("FAIL defer_commit got cycle=%0d data=%h exp <=35/0f00", first1, d1);
    end
    total++;
    if (wcount != 32 || rises != 1 || open_at != 3) begin
      bad++; $display("FAIL defer_window got len=%0d rises=%0d open=%0d exp 32/1/3", wcount, rises, open_at);
    end
    vsync_in = 1'b1;
    repeat (5) tick();
    total++;
    if (lock_bad != 0) begin
      bad++; $display("FAIL lockstep_defer n=%0d got=%h exp=%h", lock_bad, lock_act, lock_exp);
    end
    lock_bad = 0;
  endtask

  task automatic test_collision();
    int guard = 0, hits = 0, at = -1;
    logic [15:0] first_data, second_data = 16'h0;
    logic first_wr;
    logic [4:0] first_addr;
    while (m_scan[0] != 4 && guard < 40) begin tick(); guard++; end
    wr_byte(6'h06, 8'h11);
    wr_byte(6'h07, 8'h11);
    wr_byte(6'h06, 8'h55);
    while (m_scan[0] != 3 && guard < 80) begin tick(); guard++; end
    total++;
    if (guard >= 80) begin
      bad++; $display("FAIL collision_align got guard=%0d exp <80", guard);
    end
    wr_byte(6'h07, 8'h55);
    first_wr = wr0; first_addr = addr0; first_data = data0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (wr0 && addr0 == 5'd3) begin hits++; at = n; second_data = data0; end
    end
    total++;
    if (first_wr !== 1'b1 || first_addr !== 5'd3 || first_data !== 16'h1111) begin
      bad++; $display("FAIL collision_old got=%b/%0d/%h exp=1/3/1111", first_wr, first_addr, first_data);
    end
    total++;
    if (hits != 1 || at != 32 || second_data !== 16'h5555) begin
      bad++; $display("FAIL collision_new got hits=%0d at=%0d data=%h exp 1/32/5555", hits, at, second_data);
    end
    total++;
    if (lock_bad != 0) begin
      bad++; $display("FAIL lockstep_collision n=%0d got=%h exp=%h", lock_bad, lock_act, lock_exp);
    end
    lock_bad = 0;
  endtask

  task automatic test_restart();
    int wcount = 0, rises = 0;
    logic prev = win1;
    for (int n = 1; n <= 80; n++) begin
      vsync_in = (n <= 5 || n > 10) ? 1'b0 : 1'b1;
      tick();
      if (win1) wcount++;
      if (win1 && !prev) rises++;
      prev = win1;
    end
    total++;
    if (wcount != 42 || rises != 1) begin
      bad++; $display("FAIL restart_window got len=%0d rises=%0d exp 42/1", wcount, rises);
    end
    vsync_in = 1'b1;
    repeat (5) tick();
    total++;
    if (lock_bad != 0) begin
      bad++; $display("FAIL lockstep_restart n=%0d got=%h exp=%h", lock_bad, lock_act, lock_exp);
    end
    lock_bad = 0;
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 1500; n++) begin
      op = int'($urandom_range(0, 9));
      cpu_addr = 6'($urandom_range(0, 63));
      cpu_data = 8'($urandom_range(0, 255));
      cpu_wr = (op < 4) ? 1'b1 : 1'b0;
      cpu_rd = (op == 4 || op == 5) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 59) == 0) vsync_in = ~vsync_in;
      tick();
    end
    cpu_wr = 1'b0; cpu_rd = 1'b0; vsync_in = 1'b1;
    repeat (40) tick();
    total++;
    if (lock_bad != 0) begin
      bad++; $display("FAIL lockstep_random n=%0d got=%h exp=%h", lock_bad, lock_act, lock_exp);
    end
    lock_bad = 0;
  endtask

  task automatic test_reset_pending();
    int guard = 0, wrs = 0, flags = 0, nz = 0;
    for (int i = 8; i < 12; i++) begin
      wr_byte(6'(2 * i), 8'($urandom_range(1, 255)));
      wr_byte(6'(2 * i + 1), 8'($urandom_range(1, 255)));
    end
    while (m_scan[1] != 20 && guard < 40) begin tick(); guard++; end
    vsync_in = 1'b0;
    while (win1 !== 1'b1 && guard < 50) begin tick(); guard++; end
    total++;
    if (busy1 !== 1'b1 || win1 !== 1'b1) begin
      bad++; $display("FAIL pending_setup got busy=%b win=%b exp=1/1", busy1, win1);
    end
    nreset = 1'b0; vsync_in = 1'b1;
    cpu_addr = 6'h11; cpu_data = 8'hFF; cpu_wr = 1'b1; cpu_rd = 1'b1;
    repeat (2) tick();
    nreset = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0;
    total++;
    if ({wr0, busy0, win0, dout0, wr1, busy1, win1, dout1} !== 22'd0) begin
      bad++; $display("FAIL pending_reset got=%h exp=0", {wr0, busy0, win0, dout0, wr1, busy1, win1, dout1});
    end
    for (int n = 0; n < 40; n++) begin
      tick();
      if (wr0 || wr1) wrs++;
      if (busy0 || busy1 || win0 || win1) flags++;
    end
    total++;
    if (wrs != 0 || flags != 0) begin
      bad++; $display("FAIL pending_quiet got writes=%0d flagged=%0d exp 0/0", wrs, flags);
    end
    cpu_rd = 1'b1;
    for (int a = 0; a < 64; a++) begin
      cpu_addr = 6'(a);
      tick();
      if (dout0 !== 8'h00 || dout1 !== 8'h00) nz++;
    end
    cpu_rd = 1'b0;
    total++;
    if (nz != 0) begin
      bad++; $display("FAIL pending_readback got nonzero=%0d exp=0", nz);
    end
    total++;
    if (lock_bad != 0) begin
      bad++; $display("FAIL lockstep_pending n=%0d got=%h exp=%h", lock_bad, lock_act, lock_exp);
    end
    lock_bad = 0;
  endtask

  initial begin
    nreset = 1'b0; cpu_addr = 6'h00; cpu_data = 8'h00;
    cpu_wr = 1'b0; cpu_rd = 1'b0; vsync_in = 1'b1;
    test_reset();
    test_basic();
    test_readback();
    test_defer();
    test_collision();
    test_restart();
    test_random();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
